// File: rtl/top_level.sv
// Single-cycle 8-bit load/store CPU: 9-bit instruction ROM, 8x8 register file, ALU, 256x8 data RAM.
// The ROM image is supplied through PROG_IMAGE (word i at bits [9i+8:9i]); unused words read as HALT.

module top_level_rf (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr_a,
    input  logic [2:0] raddr_b,
    output logic [7:0] rdata_a_c,
    output logic [7:0] rdata_b_c,
    output logic [7:0] r7_c
);
    logic [7:0] core [0:7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) core[i] <= '0;
        end else if (we) begin
            core[waddr] <= wdata;
        end
    end

    assign rdata_a_c = core[raddr_a];
    assign rdata_b_c = core[raddr_b];
    assign r7_c      = core[7];
endmodule

module top_level #(
    parameter int unsigned               ROM_DEPTH  = 256,
    parameter logic [ROM_DEPTH*9-1:0]    PROG_IMAGE = {ROM_DEPTH{9'h1C0}}
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic done
);
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 9;
    localparam int unsigned AW = 8;

    localparam logic [2:0] OP_IMM  = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_LD   = 3'b110;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic            carry;
    logic [IW-1:0]   rom [ROM_DEPTH];
    logic [DW-1:0]   mem [256];

    logic [IW-1:0]   instr;
    logic [2:0]      op, fa, fb;
    logic [DW-1:0]   ra, rb, r7;
    logic [DW:0]     sum, diff;
    logic            exec;
    logic            rf_we, mem_we, carry_we, carry_nx, halt;
    logic [DW-1:0]   rf_wdata;
    logic [AW-1:0]   pc_nx;

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        assign rom[i] = PROG_IMAGE[i*IW +: IW];
    end

    assign instr = rom[pc];
    assign op    = instr[8:6];
    assign fa    = instr[5:3];
    assign fb    = instr[2:0];
    assign sum   = {1'b0, ra} + {1'b0, rb};
    assign diff  = {1'b0, ra} - {1'b0, rb};
    // A req edge always takes precedence over the instruction under the PC.
    assign exec  = (state == ST_RUN) && !req;

    top_level_rf rf1 (
        .clk       (clk),
        .reset     (reset),
        .we        (rf_we && exec),
        .waddr     (fa),
        .wdata     (rf_wdata),
        .raddr_a   (fa),
        .raddr_b   (fb),
        .rdata_a_c (ra),
        .rdata_b_c (rb),
        .r7_c      (r7)
    );

    // Instruction decode and ALU.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = ra;
        mem_we   = 1'b0;
        carry_we = 1'b0;
        carry_nx = carry;
        halt     = 1'b0;
        pc_nx    = pc + 8'd1;
        case (op)
            OP_IMM: begin rf_we = 1'b1; rf_wdata = {5'b0, fb}; end
            OP_MOV: begin rf_we = 1'b1; rf_wdata = rb; end
            OP_ADD: begin rf_we = 1'b1; rf_wdata = sum[7:0];  carry_we = 1'b1; carry_nx = sum[8];  end
            OP_SUB: begin rf_we = 1'b1; rf_wdata = diff[7:0]; carry_we = 1'b1; carry_nx = diff[8]; end
            OP_AND: begin rf_we = 1'b1; rf_wdata = ra & rb; end
            OP_ST:  mem_we = 1'b1;
            OP_LD:  begin rf_we = 1'b1; rf_wdata = mem[rb]; end
            default: begin
                if (fa == 3'b000) halt = 1'b1;
                else if (fa == 3'b001 && rb != 8'd0) pc_nx = r7;
            end
        endcase
    end

    // Data memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (exec && mem_we) mem[rb] <= ra;
    end

    // Control: req arms, the next req-free edge starts, then one instruction per edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (req) begin
            state <= ST_ARM;
            pc    <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_ARM: state <= ST_RUN;
                ST_RUN: begin
                    if (halt) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        pc <= pc_nx;
                        if (carry_we) carry <= carry_nx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Bench: four CPUs with different ROM images run in lockstep; a cycle-stamped scoreboard checks them.

module tb_top_level;
    localparam int unsigned DEPTH = 256;
    localparam logic [8:0]  HLT   = 9'h1C0;

    localparam logic [DEPTH*9-1:0] IMG_IMM  = {{(DEPTH-2){HLT}}, HLT, 9'b000_000_011};
    localparam logic [DEPTH*9-1:0] IMG_ALU  = {{(DEPTH-4){HLT}}, 9'b011_010_001, 9'b010_001_010,
                                               9'b000_010_101, 9'b000_001_111};
    localparam logic [DEPTH*9-1:0] IMG_MEM  = {{(DEPTH-5){HLT}}, HLT, 9'b110_011_001, 9'b101_000_001,
                                               9'b000_001_010, 9'b000_000_110};
    localparam logic [DEPTH*9-1:0] IMG_LOOP = {{(DEPTH-6){HLT}}, HLT, 9'b111_001_000, 9'b011_000_001,
                                               9'b000_111_011, 9'b000_001_001, 9'b000_000_011};

    localparam int S_CARRY = 8;
    localparam int S_DONE  = 9;
    localparam int S_PC    = 10;
    localparam int S_MEM   = 16;

    localparam int U_IMM = 0, U_ALU = 1, U_MEM = 2, U_LOOP = 3;

    typedef struct {
        int         cyc;
        int         unit;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    logic clk, reset, req;
    logic done_imm, done_alu, done_mem, done_loop;
    exp_t sb[$];
    int   n_vec, n_err;

    top_level #(.ROM_DEPTH(DEPTH), .PROG_IMAGE(IMG_IMM))  dut_imm  (.clk(clk), .reset(reset), .req(req), .done(done_imm));
    top_level #(.ROM_DEPTH(DEPTH), .PROG_IMAGE(IMG_ALU))  dut_alu  (.clk(clk), .reset(reset), .req(req), .done(done_alu));
    top_level #(.ROM_DEPTH(DEPTH), .PROG_IMAGE(IMG_MEM))  dut_mem  (.clk(clk), .reset(reset), .req(req), .done(done_mem));
    top_level #(.ROM_DEPTH(DEPTH), .PROG_IMAGE(IMG_LOOP)) dut_loop (.clk(clk), .reset(reset), .req(req), .done(done_loop));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] probe(input int unit, input int sel);
        logic [7:0] v;
        v = 8'h00;
        case (unit)
            U_IMM: case (sel)
                S_CARRY: v = {7'd0, dut_imm.carry};
                S_DONE:  v = {7'd0, done_imm};
                S_PC:    v = dut_imm.pc;
                default: v = dut_imm.rf1.core[3'(sel)];
            endcase
            U_ALU: case (sel)
                S_CARRY: v = {7'd0, dut_alu.carry};
                S_DONE:  v = {7'd0, done_alu};
                S_PC:    v = dut_alu.pc;
                default: v = dut_alu.rf1.core[3'(sel)];
            endcase
            U_MEM: begin
                if (sel >= S_MEM) v = dut_mem.mem[8'(sel - S_MEM)];
                else case (sel)
                    S_CARRY: v = {7'd0, dut_mem.carry};
                    S_DONE:  v = {7'd0, done_mem};
                    S_PC:    v = dut_mem.pc;
                    default: v = dut_mem.rf1.core[3'(sel)];
                endcase
            end
            default: case (sel)
                S_CARRY: v = {7'd0, dut_loop.carry};
                S_DONE:  v = {7'd0, done_loop};
                S_PC:    v = dut_loop.pc;
                default: v = dut_loop.rf1.core[3'(sel)];
            endcase
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int cyc, input int unit, input int sel, input logic [7:0] exp);
        exp_t e;
        e.cyc = cyc; e.unit = unit; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain(input int cyc);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check($sformatf("cyc%0d unit%0d sel%0d", cyc, sb[i].unit, sb[i].sel),
                      probe(sb[i].unit, sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    // Pulse req, then step n edges comparing due entries; optionally re-pulse req on edge abort_at.
    task automatic run_cycles(input int n, input int abort_at);
        req = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            drain(k);
            req = (k + 1 == abort_at);
        end
        req = 1'b0;
        check("scoreboard_leftover", 8'(sb.size()), 8'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        req   = 1'b0;
        repeat (2) @(negedge clk);

        for (int u = 0; u < 4; u++) begin
            push(0, u, S_DONE, 8'd0);
            push(0, u, S_PC, 8'd0);
            push(0, u, S_CARRY, 8'd0);
            push(0, u, 0, 8'd0);
        end
        drain(0);
        reset = 1'b1;

        repeat (4) @(negedge clk);
        push(0, U_IMM, S_DONE, 8'd0);
        push(0, U_LOOP, S_PC, 8'd0);
        push(0, U_IMM, 0, 8'd0);
        drain(0);

        // Run 1: every program from reset.
        push(2, U_IMM, 0, 8'd0);
        push(3, U_IMM, S_DONE, 8'd0);
        push(3, U_IMM, 0, 8'd3);
        push(4, U_IMM, S_DONE, 8'd1);
        push(4, U_IMM, S_PC, 8'd1);
        push(4, U_IMM, 1, 8'd0);
        push(4, U_IMM, 7, 8'd0);
        push(5, U_ALU, 1, 8'd12);
        push(5, U_ALU, S_CARRY, 8'd0);
        push(6, U_ALU, 2, 8'd249);
        push(6, U_ALU, S_CARRY, 8'd1);
        push(7, U_ALU, S_DONE, 8'd1);
        push(7, U_ALU, S_PC, 8'd4);
        push(6, U_MEM, S_MEM + 2, 8'd6);
        push(7, U_MEM, 3, 8'd6);
        push(7, U_MEM, S_DONE, 8'd1);
        push(6, U_LOOP, 0, 8'd2);
        push(11, U_LOOP, S_DONE, 8'd0);
        push(12, U_LOOP, S_DONE, 8'd1);
        push(12, U_LOOP, S_PC, 8'd5);
        push(12, U_LOOP, 0, 8'd0);
        push(12, U_LOOP, 1, 8'd1);
        push(12, U_LOOP, 7, 8'd3);
        push(14, U_LOOP, S_PC, 8'd5);
        run_cycles(14, 0);

        // Run 2: rerun after done, then an asynchronous reset mid-loop.
        push(1, U_IMM, S_DONE, 8'd0);
        push(1, U_LOOP, S_DONE, 8'd0);
        push(4, U_IMM, S_DONE, 8'd1);
        push(4, U_IMM, 0, 8'd3);
        push(7, U_LOOP, S_DONE, 8'd0);
        run_cycles(7, 0);
        reset = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) push(0, U_LOOP, r, 8'd0);
        push(0, U_LOOP, S_PC, 8'd0);
        push(0, U_IMM, S_DONE, 8'd0);
        push(0, U_ALU, S_CARRY, 8'd0);
        drain(0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        push(0, U_LOOP, S_DONE, 8'd0);
        push(0, U_LOOP, S_PC, 8'd0);
        push(0, U_LOOP, 7, 8'd0);
        drain(0);

        // Run 3: req lands on the loop program's HALT edge and must win.
        push(4, U_IMM, S_DONE, 8'd1);
        push(11, U_LOOP, S_DONE, 8'd0);
        push(12, U_LOOP, S_DONE, 8'd0);
        push(12, U_LOOP, S_PC, 8'd0);
        push(12, U_IMM, S_DONE, 8'd0);
        push(15, U_IMM, S_DONE, 8'd1);
        push(22, U_LOOP, S_DONE, 8'd0);
        push(23, U_LOOP, S_DONE, 8'd1);
        push(23, U_LOOP, S_PC, 8'd5);
        push(23, U_LOOP, 0, 8'd0);
        push(23, U_LOOP, 7, 8'd3);
        run_cycles(24, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
